// File: rtl/pipeline_exec_ctrl_if.sv
// Command/status bundle between the debug command decoder, the datapath
// and pipeline_exec_ctrl.
interface pipeline_exec_ctrl_if #(
    parameter int CNT_SZ = 32
);
    logic              i_run;
    logic              i_step_mode;
    logic              i_step;
    logic              i_halt_fetched;
    logic              i_stall_pc_HD;
    logic              i_clear;
    logic              o_pipe_enable;
    logic              o_pc_enable;
    logic [CNT_SZ-1:0] o_cycle_cnt;
    logic [2:0]        o_state;
    logic              o_done;
    logic              o_step_ack;

    modport master (
        output i_run, i_step_mode, i_step, i_halt_fetched, i_stall_pc_HD, i_clear,
        input  o_pipe_enable, o_pc_enable, o_cycle_cnt, o_state, o_done, o_step_ack
    );

    modport slave (
        input  i_run, i_step_mode, i_step, i_halt_fetched, i_stall_pc_HD, i_clear,
        output o_pipe_enable, o_pc_enable, o_cycle_cnt, o_state, o_done, o_step_ack
    );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: run / single-step sequencing of the PC and pipeline
// enables, HALT drain, and a saturating count of enabled cycles.
module pipeline_exec_ctrl #(
    parameter int CNT_SZ       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_exec_ctrl_if.slave  bus
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_DRAIN     = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    state_t            r_state;
    logic [DW-1:0]     r_drain;
    logic [CNT_SZ-1:0] r_cnt;
    logic              r_pipe_en;
    logic              r_done;
    logic              r_step_ack;

    state_t            w_next;
    logic              w_halt_go;
    logic              w_exec;
    logic              w_cnt_clr;

    assign w_exec    = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
    // A HALT seen while the PC is stalled is not yet committed to IF.
    assign w_halt_go = bus.i_halt_fetched & ~bus.i_stall_pc_HD;
    assign w_cnt_clr = ((r_state == S_IDLE) && (w_next != S_IDLE)) ||
                       ((r_state == S_HALTED) && (w_next == S_IDLE));

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (bus.i_run)            w_next = S_RUN;
                else if (bus.i_step_mode) w_next = S_STEP_WAIT;
                else                      w_next = S_IDLE;
            end
            S_RUN:       w_next = w_halt_go ? S_DRAIN : S_RUN;
            S_STEP_WAIT: w_next = bus.i_step ? S_STEP_EXEC : S_STEP_WAIT;
            S_STEP_EXEC: w_next = w_halt_go ? S_DRAIN : S_STEP_WAIT;
            S_DRAIN:     w_next = (r_drain == DW'(1)) ? S_HALTED : S_DRAIN;
            S_HALTED:    w_next = bus.i_clear ? S_IDLE : S_HALTED;
            default:     w_next = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_drain    <= '0;
            r_cnt      <= '0;
            r_pipe_en  <= 1'b0;
            r_done     <= 1'b0;
            r_step_ack <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pipe_en  <= (w_next == S_RUN) || (w_next == S_STEP_EXEC) || (w_next == S_DRAIN);
            r_done     <= (w_next == S_HALTED);
            r_step_ack <= (w_next == S_STEP_EXEC);

            if (w_exec && w_halt_go)
                r_drain <= DW'(DRAIN_CYCLES);
            else if (r_state == S_DRAIN && r_drain != '0)
                r_drain <= r_drain - DW'(1);

            if (w_cnt_clr)
                r_cnt <= '0;
            else if (r_pipe_en && r_cnt != '1)
                r_cnt <= r_cnt + CNT_SZ'(1);
        end
    end

    assign bus.o_pipe_enable = r_pipe_en;
    assign bus.o_pc_enable   = w_exec & ~bus.i_stall_pc_HD & ~bus.i_halt_fetched;
    assign bus.o_cycle_cnt   = r_cnt;
    assign bus.o_state       = r_state;
    assign bus.o_done        = r_done;
    assign bus.o_step_ack    = r_step_ack;
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: run-to-halt, stalls, single-step,
// ignored pulses, asynchronous reset and counter saturation.
module tb_pipeline_exec_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    pipeline_exec_ctrl_if #(.CNT_SZ(32)) bus_a ();
    pipeline_exec_ctrl_if #(.CNT_SZ(4))  bus_b ();

    pipeline_exec_ctrl #(.CNT_SZ(32), .DRAIN_CYCLES(4)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_a.slave)
    );

    pipeline_exec_ctrl #(.CNT_SZ(4), .DRAIN_CYCLES(4)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pipe_cycles;
        int ack_cycles;
        n_checks = 0;
        n_err    = 0;
        {bus_a.i_run, bus_a.i_step_mode, bus_a.i_step, bus_a.i_halt_fetched,
         bus_a.i_stall_pc_HD, bus_a.i_clear} = '0;
        {bus_b.i_run, bus_b.i_step_mode, bus_b.i_step, bus_b.i_halt_fetched,
         bus_b.i_stall_pc_HD, bus_b.i_clear} = '0;

        rst = 1'b1;
        #12;
        check("rst_state", 32'(bus_a.o_state), 0);
        check("rst_pipe",  32'(bus_a.o_pipe_enable), 0);
        check("rst_pc",    32'(bus_a.o_pc_enable), 0);
        check("rst_cnt",   bus_a.o_cycle_cnt, 0);
        check("rst_done",  32'(bus_a.o_done), 0);
        check("rst_ack",   32'(bus_a.o_step_ack), 0);
        rst = 1'b0;
        tick();

        // Run to halt: HALT in the 11th RUN cycle
        bus_a.i_run = 1'b1;
        tick();
        bus_a.i_run = 1'b0;
        check("run_state", 32'(bus_a.o_state), 1);
        check("run_pipe",  32'(bus_a.o_pipe_enable), 1);
        check("run_cnt0",  bus_a.o_cycle_cnt, 0);
        for (int k = 1; k <= 10; k++) begin
            check("run_pc", 32'(bus_a.o_pc_enable), 1);
            tick();
        end
        check("run_cnt10", bus_a.o_cycle_cnt, 10);
        bus_a.i_halt_fetched = 1'b1;
        #1;
        check("halt_pc",   32'(bus_a.o_pc_enable), 0);
        check("halt_pipe", 32'(bus_a.o_pipe_enable), 1);
        tick();
        bus_a.i_halt_fetched = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            check("drain_state", 32'(bus_a.o_state), 4);
            check("drain_pipe",  32'(bus_a.o_pipe_enable), 1);
            check("drain_pc",    32'(bus_a.o_pc_enable), 0);
            check("drain_done",  32'(bus_a.o_done), 0);
            tick();
        end
        check("halted_state", 32'(bus_a.o_state), 5);
        check("halted_done",  32'(bus_a.o_done), 1);
        check("halted_cnt",   bus_a.o_cycle_cnt, 15);
        check("halted_pipe",  32'(bus_a.o_pipe_enable), 0);

        // HALTED ignores run; clear returns to IDLE
        bus_a.i_run = 1'b1;
        tick();
        bus_a.i_run = 1'b0;
        check("halted_ign_run", 32'(bus_a.o_state), 5);
        bus_a.i_clear = 1'b1;
        tick();
        bus_a.i_clear = 1'b0;
        check("clear_state", 32'(bus_a.o_state), 0);
        check("clear_cnt",   bus_a.o_cycle_cnt, 0);
        check("clear_done",  32'(bus_a.o_done), 0);

        // Priority: run wins over step_mode; step/clear ignored in RUN
        bus_a.i_run = 1'b1;
        bus_a.i_step_mode = 1'b1;
        tick();
        bus_a.i_run = 1'b0;
        bus_a.i_step_mode = 1'b0;
        check("prio_state", 32'(bus_a.o_state), 1);
        bus_a.i_step  = 1'b1;
        bus_a.i_clear = 1'b1;
        tick();
        bus_a.i_step  = 1'b0;
        bus_a.i_clear = 1'b0;
        check("run_ign_state", 32'(bus_a.o_state), 1);
        check("run_ign_cnt",   bus_a.o_cycle_cnt, 1);

        // Hazard stall for 2 cycles, HALT during the first is ignored
        bus_a.i_stall_pc_HD  = 1'b1;
        bus_a.i_halt_fetched = 1'b1;
        #1;
        check("stall1_pc",   32'(bus_a.o_pc_enable), 0);
        check("stall1_pipe", 32'(bus_a.o_pipe_enable), 1);
        tick();
        bus_a.i_halt_fetched = 1'b0;
        check("stall2_state", 32'(bus_a.o_state), 1);
        check("stall2_cnt",   bus_a.o_cycle_cnt, 2);
        check("stall2_pc",    32'(bus_a.o_pc_enable), 0);
        check("stall2_pipe",  32'(bus_a.o_pipe_enable), 1);
        tick();
        bus_a.i_stall_pc_HD = 1'b0;
        #1;
        check("unstall_state", 32'(bus_a.o_state), 1);
        check("unstall_cnt",   bus_a.o_cycle_cnt, 3);
        check("unstall_pc",    32'(bus_a.o_pc_enable), 1);

        // Asynchronous reset after 5 RUN cycles, mid-cycle
        tick();
        tick();
        check("prerst_cnt", bus_a.o_cycle_cnt, 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(bus_a.o_state), 0);
        check("arst_pipe",  32'(bus_a.o_pipe_enable), 0);
        check("arst_pc",    32'(bus_a.o_pc_enable), 0);
        check("arst_cnt",   bus_a.o_cycle_cnt, 0);
        #10;
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("postrst_state", 32'(bus_a.o_state), 0);
        check("postrst_pipe",  32'(bus_a.o_pipe_enable), 0);

        // Single-step: 3 steps spaced 5 cycles apart
        bus_a.i_step_mode = 1'b1;
        tick();
        bus_a.i_step_mode = 1'b0;
        check("sw_state", 32'(bus_a.o_state), 2);
        check("sw_pipe",  32'(bus_a.o_pipe_enable), 0);
        pipe_cycles = 0;
        ack_cycles  = 0;
        for (int s = 0; s < 3; s++) begin
            bus_a.i_step = 1'b1;
            tick();
            bus_a.i_step = 1'b0;
            check("sx_state", 32'(bus_a.o_state), 3);
            check("sx_pc",    32'(bus_a.o_pc_enable), 1);
            for (int c = 0; c < 5; c++) begin
                if (bus_a.o_pipe_enable) pipe_cycles++;
                if (bus_a.o_step_ack)    ack_cycles++;
                tick();
            end
        end
        check("step_pipe_cycles", 32'(pipe_cycles), 3);
        check("step_ack_cycles",  32'(ack_cycles), 3);
        check("step_cnt",         bus_a.o_cycle_cnt, 3);
        check("step_state",       32'(bus_a.o_state), 2);

        // HALT during a step goes to DRAIN
        bus_a.i_step = 1'b1;
        tick();
        bus_a.i_step = 1'b0;
        bus_a.i_halt_fetched = 1'b1;
        #1;
        check("sx_halt_pc", 32'(bus_a.o_pc_enable), 0);
        tick();
        bus_a.i_halt_fetched = 1'b0;
        check("sx_drain_state", 32'(bus_a.o_state), 4);
        for (int d = 0; d < 4; d++) tick();
        check("sx_halted_state", 32'(bus_a.o_state), 5);
        check("sx_halted_cnt",   bus_a.o_cycle_cnt, 8);

        // Saturation on the 4-bit counter instance
        bus_b.i_run = 1'b1;
        tick();
        bus_b.i_run = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) check("sat_cnt14", 32'(bus_b.o_cycle_cnt), 14);
            if (k == 15) check("sat_cnt15", 32'(bus_b.o_cycle_cnt), 15);
        end
        check("sat_cnt20",  32'(bus_b.o_cycle_cnt), 15);
        check("sat_state",  32'(bus_b.o_state), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
